// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART transmitter: parity mode and transmit FSM states.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, head word visible on rdata while not empty; pushes are dropped when full.
// Pops are ignored when empty. The level counter is one bit wider than the pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full wins over a simultaneous pop: the push is refused, not folded in.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with input FIFO; frame format fixed at elaboration, LSB first, tx idle high.
// A word pushed into an empty FIFO while idle starts its start bit one cycle later; frames run back-to-back.
module uart_tx_fifo_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clkin,
  input  logic                          resetn_in,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import uart_pkg::*;

  localparam parity_e               PAR_MODE  = parity_e'(PARITY);
  localparam int                    BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]     BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]            LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]            LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_e             state;
  tx_state_e             state_d;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [3:0]            bit_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic [DATA_BITS-1:0]  fifo_rdata;
  logic                  par_acc;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  tx_d;
  logic                  baud_done;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clkin),
    .rst_n (resetn_in),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign in_ready  = ~fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign baud_done = (baud_cnt == '0);

  always_ff @(posedge clkin or negedge resetn_in) begin
    if (!resetn_in) state <= IDLE;
    else            state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:             if (!fifo_empty) state_d = START;
      START:            if (baud_done) state_d = DATA;
      DATA:             if (baud_done && bit_cnt == LAST_DATA)
                          state_d = (PAR_MODE == PAR_NONE) ? STOP : uart_pkg::PARITY;
      uart_pkg::PARITY: if (baud_done) state_d = STOP;
      STOP:             if (baud_done && bit_cnt == LAST_STOP)
                          state_d = fifo_empty ? IDLE : START;
      default:          state_d = IDLE;
    endcase
  end

  // tx is computed for the state being entered so the line itself is a flop.
  always_comb begin
    pop  = (state_d == START) && (state != START);
    tx_d = tx;
    unique case (state_d)
      IDLE:  tx_d = 1'b1;
      START: tx_d = 1'b0;
      DATA: begin
        if (state == START)  tx_d = shreg[0];
        else if (baud_done)  tx_d = shreg[1];
      end
      uart_pkg::PARITY: begin
        if (state == DATA) tx_d = par_acc ^ shreg[0] ^ (PAR_MODE == PAR_ODD);
      end
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clkin or negedge resetn_in) begin
    if (!resetn_in) begin
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
    end else begin
      tx <= tx_d;
      if (state_d == IDLE)                baud_cnt <= '0;
      else if (state == IDLE || baud_done) baud_cnt <= BAUD_MAX;
      else                                 baud_cnt <= baud_cnt - 1'b1;
      if (state_d != state)                  bit_cnt <= '0;
      else if (baud_done && state != IDLE)   bit_cnt <= bit_cnt + 1'b1;
      // Parity accumulates each data bit as it leaves the shift register.
      if (pop) begin
        shreg   <= fifo_rdata;
        par_acc <= 1'b0;
      end else if (state == DATA && baud_done) begin
        shreg   <= shreg >> 1;
        par_acc <= par_acc ^ shreg[0];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: five frame formats, table-driven single frames plus burst, reset and random streams.
module tb_uart_tx_fifo_param;

  localparam int NI = 5;

  int nbits [NI] = '{8, 8, 8, 7, 8};
  int par   [NI] = '{0, 1, 2, 0, 0};
  int stops [NI] = '{1, 1, 1, 2, 1};
  int cpb   [NI] = '{4, 4, 4, 4, 2};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] din [NI];
  logic       vld [NI];
  logic       rdy [NI];
  logic       txs [NI];
  logic       bsy [NI];
  logic [2:0] lvl [NI];

  always #1 clk = ~clk;

  uart_tx_fifo_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u0 (
    .clkin(clk), .resetn_in(rst_n), .in_data(din[0][7:0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .tx(txs[0]), .busy(bsy[0]), .fifo_level(lvl[0]));
  uart_tx_fifo_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u1 (
    .clkin(clk), .resetn_in(rst_n), .in_data(din[1][7:0]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .tx(txs[1]), .busy(bsy[1]), .fifo_level(lvl[1]));
  uart_tx_fifo_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u2 (
    .clkin(clk), .resetn_in(rst_n), .in_data(din[2][7:0]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .tx(txs[2]), .busy(bsy[2]), .fifo_level(lvl[2]));
  uart_tx_fifo_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u3 (
    .clkin(clk), .resetn_in(rst_n), .in_data(din[3][6:0]), .in_valid(vld[3]), .in_ready(rdy[3]),
    .tx(txs[3]), .busy(bsy[3]), .fifo_level(lvl[3]));
  uart_tx_fifo_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u4 (
    .clkin(clk), .resetn_in(rst_n), .in_data(din[4][7:0]), .in_valid(vld[4]), .in_ready(rdy[4]),
    .tx(txs[4]), .busy(bsy[4]), .fifo_level(lvl[4]));

  typedef struct {
    int inst;
    int data;
  } sb_t;

  typedef struct {
    int inst;
    int din;
    int exp_data;
    int exp_par;
  } vec_t;

  sb_t  sb[$];
  vec_t vt[10];
  int   nchecks = 0;
  int   nerr    = 0;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  // Holds in_valid until accepted; leaves it asserted so the caller can stream.
  task automatic push(input int idx, input int d);
    int   waited = 0;
    logic r;
    sb_t  e;
    din[idx] = 9'(d);
    vld[idx] = 1'b1;
    forever begin
      r = rdy[idx];
      @(negedge clk);
      if (r) break;
      waited++;
      if (waited > 3000) begin
        nchecks++;
        nerr++;
        $display("FAIL push_timeout: inst %0d word %0d never accepted, acceptance required", idx, d);
        break;
      end
    end
    e.inst = idx;
    e.data = d & ((1 << nbits[idx]) - 1);
    sb.push_back(e);
  endtask

  task automatic sample_bit(input int idx, output int v, inout int ok, output int b);
    v = int'(txs[idx]);
    b = 0;
    for (int c = 0; c < cpb[idx]; c++) begin
      if (int'(txs[idx]) != v) ok = 0;
      b = int'(bsy[idx]);
      @(negedge clk);
    end
  endtask

  // Receiver model: every cycle of every bit must hold the same level.
  task automatic rx(input int idx, output int data, output int parbit, output int gap,
                    output int ok, output int busy_last);
    int v;
    data = 0; parbit = -1; gap = 0; ok = 1; busy_last = 0;
    while (txs[idx] !== 1'b0) begin
      if (gap >= 3000) begin
        ok = 0;
        return;
      end
      gap++;
      @(negedge clk);
    end
    sample_bit(idx, v, ok, busy_last);
    for (int i = 0; i < nbits[idx]; i++) begin
      sample_bit(idx, v, ok, busy_last);
      data = data | ((v & 1) << i);
    end
    if (par[idx] != 0) begin
      sample_bit(idx, parbit, ok, busy_last);
      if (parbit != (($countones(data) & 1) ^ ((par[idx] == 2) ? 1 : 0))) ok = 0;
    end
    for (int s = 0; s < stops[idx]; s++) begin
      sample_bit(idx, v, ok, busy_last);
      if (v != 1) ok = 0;
    end
  endtask

  task automatic rx_check(input int idx, input string tag, output int data, output int gap,
                          output int parbit, output int busy_last);
    int  ok;
    sb_t e;
    rx(idx, data, parbit, gap, ok, busy_last);
    check({tag, "_frame_ok"}, ok, 1);
    if (sb.size() == 0) begin
      nchecks++;
      nerr++;
      $display("FAIL %s_scoreboard: received %0d, required a queued word", tag, data);
    end else begin
      e = sb.pop_front();
      check({tag, "_data"}, data, e.data);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before time 100000");
    $fatal(1);
  end

  initial begin
    int data, gap, parbit, bl, stale;
    int words [6] = '{'h11, 'h22, 'h33, 'h44, 'h55, 'h66};

    vt[0] = '{0, 'hA5,  'hA5, -1};
    vt[1] = '{1, 'h07,  'h07,  1};
    vt[2] = '{2, 'h07,  'h07,  0};
    vt[3] = '{1, 'h81,  'h81,  0};
    vt[4] = '{2, 'h81,  'h81,  1};
    vt[5] = '{0, 'h00,  'h00, -1};
    vt[6] = '{0, 'hFF,  'hFF, -1};
    vt[7] = '{3, 'h1FF, 'h7F, -1};
    vt[8] = '{1, 'h00,  'h00,  0};
    vt[9] = '{2, 'h00,  'h00,  1};

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      vld[i] = 1'b0;
      din[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("reset_tx", int'(txs[i]), 1);
      check("reset_in_ready", int'(rdy[i]), 1);
      check("reset_busy", int'(bsy[i]), 0);
      check("reset_level", int'(lvl[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single frames: start bit one cycle after the push, exact frame length via busy.
    for (int i = 0; i < 10; i++) begin
      push(vt[i].inst, vt[i].din);
      vld[vt[i].inst] = 1'b0;
      check("vec_level_after_push", int'(lvl[vt[i].inst]), 1);
      check("vec_busy_after_push", int'(bsy[vt[i].inst]), 1);
      rx_check(vt[i].inst, "vec", data, gap, parbit, bl);
      check("vec_start_delay", gap, 1);
      check("vec_data_table", data, vt[i].exp_data);
      if (vt[i].exp_par >= 0) check("vec_parity_bit", parbit, vt[i].exp_par);
      check("vec_busy_last_stop", bl, 1);
      check("vec_busy_after_frame", int'(bsy[vt[i].inst]), 0);
      check("vec_tx_idle", int'(txs[vt[i].inst]), 1);
      check("vec_level_after_frame", int'(lvl[vt[i].inst]), 0);
    end

    // Back-to-back frames with two stop bits: no idle gap between them.
    push(3, 'h7F);
    push(3, 'h00);
    vld[3] = 1'b0;
    rx_check(3, "b2b_first", data, gap, parbit, bl);
    check("b2b_busy_between", int'(bsy[3]), 1);
    rx_check(3, "b2b_second", data, gap, parbit, bl);
    check("b2b_gap", gap, 0);
    check("b2b_busy_end", int'(bsy[3]), 0);

    // Six words against a depth-4 FIFO with in_valid held.
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          push(0, words[k]);
          if (k == 4) begin
            check("burst_level_full", int'(lvl[0]), 4);
            check("burst_in_ready_full", int'(rdy[0]), 0);
          end
        end
        vld[0] = 1'b0;
      end
      begin
        for (int k = 0; k < 6; k++) begin
          int d6, g6, p6, b6;
          rx_check(0, "burst", d6, g6, p6, b6);
          if (k > 0) check("burst_gap", g6, 0);
        end
      end
    join
    check("burst_busy_end", int'(bsy[0]), 0);

    // Reset in the middle of a data bit with two words queued.
    push(0, 'h00);
    push(0, 'h5A);
    push(0, 'hC3);
    vld[0] = 1'b0;
    check("rst_level_before", int'(lvl[0]), 2);
    repeat (10) @(negedge clk);
    check("rst_tx_mid_data", int'(txs[0]), 0);
    @(posedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", int'(txs[0]), 1);
    check("rst_mid_level", int'(lvl[0]), 0);
    check("rst_mid_busy", int'(bsy[0]), 0);
    check("rst_mid_in_ready", int'(rdy[0]), 1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (100) begin
      if (txs[0] !== 1'b1 || bsy[0] !== 1'b0) stale++;
      @(negedge clk);
    end
    check("rst_no_stale_frame", stale, 0);
    push(0, 'h3C);
    vld[0] = 1'b0;
    rx_check(0, "rst_after", data, gap, parbit, bl);
    check("rst_after_gap", gap, 1);

    // Random stream at the minimum divisor.
    fork
      begin
        for (int k = 0; k < 50; k++) begin
          push(4, int'($urandom_range(0, 255)));
          if ($urandom_range(0, 3) == 0) begin
            vld[4] = 1'b0;
            repeat ($urandom_range(1, 30)) @(negedge clk);
          end
        end
        vld[4] = 1'b0;
      end
      begin
        for (int k = 0; k < 50; k++) begin
          int dr, gr, pr, br;
          rx_check(4, "rand", dr, gr, pr, br);
        end
      end
    join
    check("rand_scoreboard_drained", sb.size(), 0);
    check("rand_busy_end", int'(bsy[4]), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
